// File: rtl/link_arbiter_pkg.sv
// Shared interconnect types: the link packet format and
// the link arbiter's default burst allowance.
package link_arbiter_pkg;

    // Transfers one owner may complete back-to-back before
    // priority is forced to rotate.
    localparam int TIA_LINK_ARBITER_MAX_BURST = 1;

    localparam int PKT_DEST_W    = 4;
    localparam int PKT_VC_W      = 2;
    localparam int PKT_PAYLOAD_W = 26;

    typedef struct packed {
        logic [PKT_DEST_W-1:0]    dest;
        logic [PKT_VC_W-1:0]      vc;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } packet_t;

    // Circular successor of idx in a ring of n entries.
    function automatic int unsigned ring_next(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/link_arbiter_rr_priority_picker.sv
// Circular first-one finder: returns the first asserted
// request at or after ptr_i, wrapping N-1 -> 0.
//   req_i   : request vector
//   ptr_i   : position with highest priority
//   found_o : any request asserted
//   index_o : chosen position (0 when none)
module rr_priority_picker #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] idx;

    // Scan from the farthest position back toward ptr_i so
    // the nearest asserted request is the last one written.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                found_o = 1'b1;
                index_o = idx;
            end
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Round-robin link arbiter with grant locking and a burst
// allowance, sharing one link among NUM_REQUESTERS senders.
//   clock, reset : clock, async active-high reset
//   enable       : when low the link idles and state holds
//   in_req       : per-sender request
//   in_packet    : per-sender packet
//   in_ack       : per-sender ack, one-hot or zero
//   out_req      : shared link request
//   out_packet   : shared link packet
//   out_ack      : shared link ack
//   grant_valid  : a sender is selected
//   grant_index  : selected sender
//   quiescent    : no sender is requesting
module link_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_BURST      = TIA_LINK_ARBITER_MAX_BURST,
    localparam int IW = $clog2(NUM_REQUESTERS),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_REQUESTERS-1:0]          in_req,
    input  packet_t [NUM_REQUESTERS-1:0]       in_packet,
    output logic [NUM_REQUESTERS-1:0]          in_ack,
    output logic                               out_req,
    output packet_t                            out_packet,
    input  logic                               out_ack,
    output logic                               grant_valid,
    output logic [IW-1:0]                      grant_index,
    output logic                               quiescent
);

    logic          owner_valid_q, owner_valid_d;
    logic [IW-1:0] owner_index_q, owner_index_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_count_q, burst_count_d;

    logic          pick_found;
    logic [IW-1:0] pick_index;
    logic          owner_hit;
    logic [IW-1:0] sel;
    logic [IW-1:0] sel_next;
    logic [CW-1:0] burst_eff;
    logic          burst_last;

    rr_priority_picker #(
        .N (NUM_REQUESTERS)
    ) u_picker (
        .req_i   (in_req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .index_o (pick_index)
    );

    // A lock only holds while its owner still requests; a
    // drained owner falls back to the round-robin scan.
    assign owner_hit = owner_valid_q && in_req[owner_index_q];
    assign sel       = owner_hit ? owner_index_q : pick_index;
    assign sel_next  = IW'(ring_next(int'(sel), NUM_REQUESTERS));

    // A newly selected sender starts its burst from zero.
    assign burst_eff  = owner_hit ? burst_count_q : '0;
    assign burst_last = (int'(burst_eff) + 1) >= MAX_BURST;

    assign grant_valid = enable && pick_found;
    assign grant_index = grant_valid ? sel : '0;
    assign out_req     = grant_valid;
    assign out_packet  = grant_valid ? in_packet[sel] : '0;
    assign quiescent   = ~|in_req;

    always_comb begin
        in_ack = '0;
        if (grant_valid && out_ack) begin
            in_ack[sel] = 1'b1;
        end
    end

    always_comb begin
        owner_valid_d = owner_valid_q;
        owner_index_d = owner_index_q;
        rr_ptr_d      = rr_ptr_q;
        burst_count_d = burst_count_q;
        if (enable) begin
            if (!grant_valid) begin
                owner_valid_d = 1'b0;
                burst_count_d = '0;
            end else if (!out_ack) begin
                // Stalled: pin the grant until the link acks.
                owner_valid_d = 1'b1;
                owner_index_d = sel;
                burst_count_d = burst_eff;
            end else if (burst_last) begin
                owner_valid_d = 1'b0;
                burst_count_d = '0;
                rr_ptr_d      = sel_next;
            end else begin
                owner_valid_d = 1'b1;
                owner_index_d = sel;
                burst_count_d = burst_eff + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_valid_q <= 1'b0;
            owner_index_q <= '0;
            rr_ptr_q      <= '0;
            burst_count_q <= '0;
        end else begin
            owner_valid_q <= owner_valid_d;
            owner_index_q <= owner_index_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_count_q <= burst_count_d;
        end
    end

endmodule

// File: doc/link_arbiter.md
Name: link_arbiter

Overview:
Shares one physical link among NUM_REQUESTERS link senders, typically several output channel buffers feeding a single router port. Arbitration is round-robin with grant locking, so a requester's packet stays on the link until it is acked. An optional burst allowance lets the owner keep the link for up to MAX_BURST consecutive transfers before priority rotates. Sits between the per-channel output buffers and the shared link toward the interconnect.

Parameters:
NUM_REQUESTERS, 4, number of upstream senders; must be >= 2.
MAX_BURST, TIA_LINK_ARBITER_MAX_BURST (default 1), transfers one owner may complete back-to-back before a forced rotation; must be >= 1.

Ports:
clock  input  1  positive-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  active-high; when low the link is idle and state holds
in_req  input  NUM_REQUESTERS  per-requester request (link req)
in_packet  input  NUM_REQUESTERS x packet_t  per-requester packet
in_ack  output  NUM_REQUESTERS  per-requester ack; one-hot or zero
out_req  output  1  shared link request
out_packet  output  packet_t  shared link packet
out_ack  input  1  shared link ack; transfer occurs when out_req && out_ack in the same cycle
grant_valid  output  1  a requester is currently selected
grant_index  output  $clog2(NUM_REQUESTERS)  selected requester
quiescent  output  1  no requester is asserting in_req

Behaviour:
- State: owner_valid (1b), owner_index, rr_ptr ($clog2(N) bits), burst_count ($clog2(MAX_BURST+1) bits). All are 0 on reset. The reset is asynchronous and may arrive mid-transfer; it drops any lock immediately.
- Selection (combinational):
  - If owner_valid && in_req[owner_index], select owner_index.
  - Otherwise select the first asserted in_req scanning circularly from rr_ptr upward, wrapping N-1 -> 0.
  - grant_valid = enable && |in_req.
  - grant_index = the selected index, or 0 when grant_valid is low.
- Outputs:
  - out_req = grant_valid.
  - out_packet = in_packet[selected] when grant_valid is high, else '0.
  - in_ack[i] = out_ack && grant_valid && (selected == i).
  - quiescent = ~|in_req, independent of enable.
  - After reset: out_req=0, out_packet='0, in_ack=0, grant_valid=0, grant_index=0.
- Latency: zero cycles. The shared link reflects the selected requester in the same cycle. out_ack returns combinationally to exactly one in_ack.
- Sequential updates, applied only when enable=1:
  - grant_valid && !out_ack (stall): owner_valid<=1, owner_index<=selected, burst_count holds. The grant cannot move while the link is stalled.
  - grant_valid && out_ack && (burst_count+1 == MAX_BURST): owner_valid<=0, burst_count<=0, rr_ptr<=(selected+1) mod N.
  - grant_valid && out_ack && (burst_count+1 < MAX_BURST): owner_valid<=1, owner_index<=selected, burst_count<=burst_count+1.
  - owner_valid && !in_req[owner_index] (owner drained): treat as released. Selection falls to the round-robin scan that cycle. If the new selection differs from owner_index, burst_count restarts from 0 for that transfer.
  - !grant_valid: owner_valid<=0, burst_count<=0, rr_ptr holds.
- enable=0: out_req=0, in_ack=0, and all state holds.
- A locked owner never has its req dropped by a well-behaved sender (its FIFO is non-empty until acked). The arbiter does not need to handle a req drop while stalled beyond the owner-drained rule above.
- Simultaneous events: a single requester asserting every cycle with MAX_BURST=1 is granted every cycle; rotation to an idle pointer is harmless.
- Fairness: with MAX_BURST=B, each continuously requesting sender waits at most (N-1)*B transfers.

Decomposition:
- The shared interconnect package already holds packet_t. Add the constant TIA_LINK_ARBITER_MAX_BURST (default 1) there.
- One combinational sub-module is natural: rr_priority_picker.
  - Parameter N.
  - Inputs: request vector, rotate pointer.
  - Outputs: found flag, index.
- The arbiter keeps the state registers, mux, and ack demux.

Test Plan:
1. Reset mid-stall: N=4, in_req=0b0100, out_ack=0 for 3 cycles, assert reset -> grant_valid=0, owner cleared, in_ack=0, rr_ptr=0 on the next cycle.
2. Round-robin rotation: MAX_BURST=1, in_req=0b1111, out_ack=1 constant -> grant_index sequence 0,1,2,3,0. Each in_ack is one-hot, matching grant_index.
3. Stall lock: MAX_BURST=1, in_req=0b0011, out_ack=0 for 4 cycles then 1 -> grant_index stays 0 through all 5 cycles; in_ack=0b0001 only in cycle 5; next grant is 1.
4. Burst allowance: MAX_BURST=2, in_req=0b0101, out_ack=1 -> grant_index sequence 0,0,2,2,0,0.
5. Enable gating: in_req=0b1000, enable=0 for 2 cycles -> out_req=0, in_ack=0, quiescent=0. With enable=1 and out_ack=1 -> in_ack=0b1000 and rr_ptr becomes 0 (wrap).
6. Owner drains: MAX_BURST=4, in_req 0b0011, requester 0 drops req after one ack -> the next cycle grants index 1 with burst_count restarted; out_packet equals in_packet[1].
